// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: a DEPTH-entry FIFO filled from the shared bus.
// The head entry is presented as opcode plus a tri-stated operand, or a NOP when the queue is empty.
module instruction_prefetch_queue #(
  parameter int unsigned                 DATA_WIDTH   = 8,
  parameter int unsigned                 OPCODE_WIDTH = 4,
  parameter int unsigned                 DEPTH        = 4,
  parameter logic [DATA_WIDTH-1:0]       NOP_INSTR    = 8'h10
) (
  input  logic                           clk,
  input  logic                           clear,
  input  logic                           n_load,
  input  logic                           n_advance,
  input  logic                           n_enable,
  inout  wire  [DATA_WIDTH-1:0]          bus,
  output logic [OPCODE_WIDTH-1:0]        opcode,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full,
  output logic                           overflow
);

  localparam int unsigned OPERAND_WIDTH = DATA_WIDTH - OPCODE_WIDTH;
  localparam int unsigned PTR_W         = $clog2(DEPTH);
  localparam int unsigned CNT_W         = PTR_W + 1;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     empty_q, empty_d;
  logic                     full_q, full_d;
  logic                     overflow_q, overflow_d;

  logic                     push_req;
  logic                     do_push;
  logic                     do_pop;
  logic [DATA_WIDTH-1:0]    head_instr;
  logic [OPERAND_WIDTH-1:0] head_operand;

  // A push while we drive the bus would capture our own operand, so it is suppressed.
  assign push_req = !n_load && n_enable;
  assign do_pop   = !n_advance && !empty_q;
  assign do_push  = push_req && (!full_q || do_pop);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (do_push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (push_req && full_q && !do_pop) begin
      overflow_d = 1'b1;
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage carries no reset; contents are only observed behind the empty flag.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[tail_q] <= bus;
    end
  end

  assign head_instr   = empty_q ? NOP_INSTR : mem_q[head_q];
  assign head_operand = head_instr[OPERAND_WIDTH-1:0];
  assign opcode       = head_instr[DATA_WIDTH-1 -: OPCODE_WIDTH];

  assign bus = n_enable ? {DATA_WIDTH{1'bz}}
                        : {{OPCODE_WIDTH{1'bz}}, head_operand};

  assign count    = count_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_instruction_prefetch_queue;

  logic       clk = 1'b0;
  logic       clear;
  logic       n_load, n_advance, n_enable;
  logic       tb_drv;
  logic [7:0] tb_data;
  wire  [7:0] bus;
  logic [3:0] opcode;
  logic [2:0] count;
  logic       empty, full, overflow;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  logic [7:0] model_q [$];
  logic       model_ovf;

  assign bus = tb_drv ? tb_data : 8'bzzzzzzzz;

  always #5 clk = ~clk;

  instruction_prefetch_queue dut (
    .clk       (clk),
    .clear     (clear),
    .n_load    (n_load),
    .n_advance (n_advance),
    .n_enable  (n_enable),
    .bus       (bus),
    .opcode    (opcode),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_head();
    return (model_q.size() == 0) ? 8'h10 : model_q[0];
  endfunction

  task automatic check_state(input string tag);
    logic [7:0] h;
    h = model_head();
    check_val({tag, "_count"}, 32'(count), 32'(model_q.size()));
    check_val({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check_val({tag, "_full"}, 32'(full), 32'(model_q.size() == 4));
    check_val({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    check_val({tag, "_opcode"}, 32'(opcode), 32'(h[7:4]));
  endtask

  // One clock of traffic: inputs set at negedge, bus checked before the edge, state after it.
  task automatic step(input string tag, input logic load, input logic adv, input logic en,
                      input logic [7:0] d);
    logic [7:0] h;
    logic       pop, push_req;
    @(negedge clk);
    n_load    = !load;
    n_advance = !adv;
    n_enable  = !en;
    tb_drv    = load && !en;
    tb_data   = d;
    #1;
    if (en) begin
      h = model_head();
      check_val({tag, "_bus"}, 32'(bus[3:0]), 32'(h[3:0]));
    end
    @(posedge clk);
    push_req = load && !en;
    pop      = adv && (model_q.size() > 0);
    if (push_req && model_q.size() == 4 && !pop) model_ovf = 1'b1;
    else if (push_req) begin
      if (pop) void'(model_q.pop_front());
      model_q.push_back(d);
      pop = 1'b0;
    end
    if (pop) void'(model_q.pop_front());
    #1;
    check_state(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    clear     = 1'b1;
    tb_drv    = 1'b0;
    n_load    = 1'b1;
    n_advance = 1'b1;
    n_enable  = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    check_state(tag);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    clear     = 1'b1;
    n_load    = 1'b1;
    n_advance = 1'b1;
    n_enable  = 1'b1;
    tb_drv    = 1'b0;
    tb_data   = 8'h00;
    model_ovf = 1'b0;
    #12;
    check_state("por");
    @(negedge clk);
    clear = 1'b0;

    // Asynchronous clear with two entries queued
    step("t1_push", 1, 0, 0, 8'hA5);
    step("t1_push", 1, 0, 0, 8'hB6);
    do_reset("t1_clear");

    // Two pushes, operand on the bus, one pop
    step("t2_push", 1, 0, 0, 8'h2A);
    check_val("t2_op0", 32'(opcode), 32'h2);
    step("t2_push", 1, 0, 0, 8'h3F);
    step("t2_drv", 0, 0, 1, 8'h00);
    step("t2_pop", 0, 1, 1, 8'h00);
    check_val("t2_op1", 32'(opcode), 32'h3);
    step("t2_drv", 0, 0, 1, 8'h00);
    check_val("t2_busF", 32'(bus[3:0]), 32'hF);
    do_reset("t2_clear");

    // Fill, overflow, drain
    step("t3_push", 1, 0, 0, 8'h11);
    step("t3_push", 1, 0, 0, 8'h22);
    step("t3_push", 1, 0, 0, 8'h33);
    step("t3_push", 1, 0, 0, 8'h44);
    check_val("t3_full", 32'(full), 32'h1);
    step("t3_ovf", 1, 0, 0, 8'h55);
    check_val("t3_ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < 4; i++) step("t3_pop", 0, 1, 0, 8'h00);
    check_val("t3_nop", 32'(opcode), 32'h1);
    do_reset("t3_clear");

    // Push+pop on a full queue, then pointer wrap
    for (int i = 0; i < 4; i++) step("t4_fill", 1, 0, 0, 8'(8'h11 * (i + 1)));
    step("t4_pp", 1, 1, 0, 8'h66);
    check_val("t4_count", 32'(count), 32'h4);
    check_val("t4_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 3; i++) step("t4_pop", 0, 1, 0, 8'h00);
    check_val("t4_wrap", 32'(opcode), 32'h6);
    do_reset("t4_clear");

    // Pop on empty, push+pop on empty
    step("t5_pop", 0, 1, 0, 8'h00);
    step("t5_pp", 1, 1, 0, 8'h77);
    check_val("t5_count", 32'(count), 32'h1);
    check_val("t5_op", 32'(opcode), 32'h7);

    // Load while driving is suppressed
    step("t6_ld_en", 1, 0, 1, 8'h00);
    check_val("t6_count", 32'(count), 32'h1);
    do_reset("t6_clear");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset("rnd_clear");
      else step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
